// File: rtl/jk_seq_pkg.sv
// ---------------------------------------------------------------------------
// jk_seq_pkg
// Shared definitions for the JK-cell sequencer:
//   - command op-code encodings
//   - sequencer FSM state type
//   - helper that tells legal op-codes from illegal ones
// ---------------------------------------------------------------------------
package jk_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_UP     = 3'b100;
    localparam logic [2:0] OP_DOWN   = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Codes 110 and 111 are unassigned; everything up to DOWN is legal.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_DOWN);
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// ---------------------------------------------------------------------------
// jk_ff_cell
// Single-bit JK flip-flop, rising-edge, synchronous active-high reset to 0.
//   clk_i  clock
//   rst_i  synchronous reset, forces q_o to 0
//   j_i    J excitation
//   k_i    K excitation
//   q_o    stored bit
// J/K = 00 hold, 01 clear, 10 set, 11 toggle.
// ---------------------------------------------------------------------------
module jk_ff_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// ---------------------------------------------------------------------------
// jk_seq_ctrl
// Command-driven sequencer for a bank of WIDTH JK cells. Each cycle it
// produces the J/K excitation that realises clear, load, toggle-mask and
// multi-step up/down counting, and applies it to the internal JK bank.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  block can accept a command (FSM in IDLE)
//   cmd_op     operation code (see jk_seq_pkg)
//   cmd_data   load value or toggle mask
//   cmd_steps  number of count steps for UP/DOWN
//   q          JK bank state
//   j_vec      J excitation applied to the bank this cycle
//   k_vec      K excitation applied to the bank this cycle
//   busy       command executing (EXEC or RUN)
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done when the op was illegal
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; op/data/steps are latched on that edge. cmd_valid
// while cmd_ready is 0 is ignored (no queuing); the source must hold the
// command until it sees the transfer edge.
// ---------------------------------------------------------------------------
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             accept;

    // Bit i toggles when every lower bit of v is 1; bit 0 always toggles.
    // Feeding q gives an up-count step, feeding ~q a down-count step.
    function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        logic             acc;
        m   = '0;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = acc;
            acc  = acc & v[i];
        end
        return m;
    endfunction

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    rem_d  = '0;
                    case (cmd_op)
                        OP_CLEAR, OP_LOAD, OP_TOGGLE: state_d = S_EXEC;
                        OP_UP, OP_DOWN: begin
                            if (cmd_steps == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_RUN;
                                rem_d   = cmd_steps;
                            end
                        end
                        default: state_d = S_DONE;  // NOP and illegal codes
                    endcase
                end
            end
            S_EXEC: state_d = S_DONE;
            S_RUN: begin
                rem_d = rem_q - REM_ONE;
                if (rem_q == REM_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Excitation: zero (hold) everywhere except EXEC and RUN.
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_CLEAR: begin
                    j_vec = '0;
                    k_vec = '1;
                end
                OP_LOAD: begin
                    j_vec = data_q;
                    k_vec = ~data_q;
                end
                OP_TOGGLE: begin
                    j_vec = data_q;
                    k_vec = data_q;
                end
                default: begin
                    j_vec = '0;
                    k_vec = '0;
                end
            endcase
        end else if (state_q == S_RUN) begin
            if (op_q == OP_DOWN) begin
                j_vec = toggle_mask(~q);
            end else begin
                j_vec = toggle_mask(q);
            end
            k_vec = j_vec;
        end
    end

    assign busy = (state_q == S_EXEC) || (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign err  = done && !op_is_legal(op_q);

    // JK storage bank
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff_cell u_cell (
            .clk_i (clk),
            .rst_i (rst),
            .j_i   (j_vec[g]),
            .k_i   (k_vec[g]),
            .q_o   (q[g])
        );
    end

endmodule
